event_prescaler16: RTL and testbench
====================================

// Module: event_prescaler16
// PURPOSE
//   Programmable event source that produces the counter_event strobe for the
//   16-bit countdown timer/counter. Two sources: internal sysclk ticks, or an
//   external pin. The pin path is synchronised, glitch-filtered and
//   edge-qualified. Either source is divided by a loadable 16-bit prescaler.
//   counter_event is a registered 1-cycle pulse, always followed by >=1 low
//   cycle, so the timer's rising-edge detector sees every event.
// PARAMETERS
//   FILTER_LEN  4  cycles ext level must be stable before filtered level follows (min 2)
// PORTS
//   sysclk         in   1   system clock
//   sysreset       in   1   asynchronous, active-high reset
//   data_in        in   16  write data bus
//   load_divisor   in   1   divisor <= data_in
//   load_ctrl      in   1   ctrl <= data_in[3:0]
//   rd_sel         in   1   data_out select: 0=divisor, 1={12'b0,ctrl}
//   data_out       out  16  readback mux (combinational from registers)
//   ext_in         in   1   asynchronous external event pin
//   counter_event  out  1   1-cycle event pulse to timer
// BEHAVIOUR
// - Reset: divisor=0, ctrl=0 (disabled), prescale count=1, sync/filter/edge regs=0,
//   counter_event=0, data_out=0.
// - ctrl[0]: enable.
// - ctrl[1]: source, 0=internal (every sysclk counts), 1=external.
// - ctrl[3:2]: edge select, 00=rise, 01=fall, 10=both, 11=rise.
// - Effective divisor E = (divisor==0) ? 1 : divisor. The period is E+1 source
//   events; this guarantees the low gap between pulses.
// - Prescale count: on each source event while enabled: if count==0, pulse
//   counter_event next cycle and count<=E; else count<=count-1.
// - Internal mode: enable written at edge t -> first pulse high in cycle t+E+1,
//   then one pulse every E+1 cycles.
// - External path runs even when disabled, so enabling causes no spurious edge.
//   - 2-FF synchroniser.
//   - Filter: filtered level takes the synced value after FILTER_LEN consecutive
//     equal samples; shorter glitches are ignored.
//   - Qualifying edge = filtered-level change matching the edge select.
// - External latency (E=1, count=0): ext_in change -> counter_event high
//   2+FILTER_LEN+1 edges later.
// - load_divisor or a 0->1 transition of ctrl[0]: count <= new E (phase restart).
// - Loads take priority over a coincident terminal event: no pulse that cycle.
// - Simultaneous load_divisor+load_ctrl: both regs written; count <= new E.
// - Disabled: count holds; counter_event=0. A pulse already registered completes.
// - Source switch via load_ctrl: count <= E; no pulse in the switch cycle.
// - sysreset mid-operation: all state clears immediately; any pulse in flight is
//   dropped.
// TESTING
// - Reset, write divisor=3, ctrl=0x1 -> pulses every 4 cycles, first 4 cycles
//   after enable; each pulse exactly 1 cycle wide.
// - divisor=0, internal -> pulse every 2 cycles (clamp); never high 2 cycles running.
// - ctrl=0x3 (ext, rise), FILTER_LEN=4, divisor=0:
//   - 3-cycle glitch on ext_in -> no pulse.
//   - Clean rising step -> pulse 7 edges later.
//   - Falling step -> no pulse.
//   - With ctrl=0xB (both edges), each step gives a pulse.
// - ctrl=0x3, divisor=2 -> one pulse per 3 qualifying rising edges; drive
//   counter_event into the timer (load 5) -> reaches 0 after 15 edges, holds.
// - load_divisor asserted in the cycle count hits 0 -> no pulse; next pulse
//   E+1 events later.
// - sysreset asserted mid-count -> counter_event=0, readback divisor=0 and
//   ctrl=0 in the same cycle.

Source files
------------

// File: rtl/event_prescaler16.sv
// event_prescaler16: event strobe source for the 16-bit countdown timer.
// Selects internal sysclk ticks or a synchronised, glitch-filtered,
// edge-qualified external pin, and divides the chosen source by a loadable
// prescaler. counter_event is a registered single-cycle pulse that is always
// followed by at least one low cycle.
module event_prescaler16 #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] data_in,
  input  logic        load_divisor,
  input  logic        load_ctrl,
  input  logic        rd_sel,
  output logic [15:0] data_out,
  input  logic        ext_in,
  output logic        counter_event
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  logic [15:0]   divisor_q, divisor_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [15:0]   count_q, count_d;
  logic          event_q, event_d;
  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          filt_prev_q;
  logic [FW-1:0] fcnt_q, fcnt_d;

  logic [15:0]   eff_div;
  logic          ext_edge;
  logic          src_event;
  logic          restart;
  logic          any_load;

  // Glitch filter: follow the synced level only after FILTER_LEN consecutive
  // samples that disagree with the current filtered level.
  always_comb begin
    fcnt_d = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Edge qualification of the filtered level and source selection.
  always_comb begin
    case (ctrl_q[3:2])
      2'b01:   ext_edge = filt_prev_q & ~filt_q;
      2'b10:   ext_edge = filt_prev_q ^ filt_q;
      default: ext_edge = filt_q & ~filt_prev_q;
    endcase
    src_event = ctrl_q[1] ? ext_edge : 1'b1;
  end

  // Register writes, phase restart and prescale countdown.
  // Any register write suppresses event processing for that cycle; only a
  // divisor write, an enable 0->1 or a source change restart the phase.
  always_comb begin
    divisor_d = load_divisor ? data_in : divisor_q;
    ctrl_d    = load_ctrl ? data_in[3:0] : ctrl_q;
    eff_div   = (divisor_d == '0) ? 16'd1 : divisor_d;
    restart   = load_divisor
              | (load_ctrl & ((~ctrl_q[0] & data_in[0]) | (ctrl_q[1] ^ data_in[1])));
    any_load  = load_divisor | load_ctrl;
    count_d   = count_q;
    event_d   = 1'b0;
    if (restart) begin
      count_d = eff_div;
    end else if (!any_load && ctrl_q[0] && src_event) begin
      if (count_q == '0) begin
        event_d = 1'b1;
        count_d = eff_div;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
  end

  // State registers; the external path runs regardless of enable.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      divisor_q   <= '0;
      ctrl_q      <= '0;
      count_q     <= 16'd1;
      event_q     <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      fcnt_q      <= '0;
    end else begin
      divisor_q   <= divisor_d;
      ctrl_q      <= ctrl_d;
      count_q     <= count_d;
      event_q     <= event_d;
      sync1_q     <= ext_in;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  assign data_out      = rd_sel ? {12'b0, ctrl_q} : divisor_q;
  assign counter_event = event_q;

endmodule

// File: tb/tb_event_prescaler16.sv
// Bench for event_prescaler16: a reference model predicts the cycle of every
// counter_event pulse and queues it; a monitor pops and compares as pulses
// appear. Directed sequences plus a randomized phase drive the design.
module tb_event_prescaler16;

  localparam int unsigned FL = 4;

  logic        sysclk = 1'b0;
  logic        sysreset = 1'b1;
  logic [15:0] data_in = '0;
  logic        load_divisor = 1'b0;
  logic        load_ctrl = 1'b0;
  logic        rd_sel = 1'b0;
  logic [15:0] data_out;
  logic        ext_in = 1'b0;
  logic        counter_event;

  event_prescaler16 #(.FILTER_LEN(FL)) dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .data_in       (data_in),
    .load_divisor  (load_divisor),
    .load_ctrl     (load_ctrl),
    .rd_sel        (rd_sel),
    .data_out      (data_out),
    .ext_in        (ext_in),
    .counter_event (counter_event)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int timer = 0;

  // Reference model state
  int   exp_q[$];
  bit   hist[$];
  int   mdiv = 0;
  int   mctrl = 0;
  int   mcount = 1;
  bit   lvl = 1'b0;
  bit   chg = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit samp(input int j);
    if (j < 2) return 1'b0;
    return hist[j-2];
  endfunction

  // Reference model, evaluated at each rising edge from the architectural rules
  initial begin
    forever begin
      int  n, neweff, ndiv, nctrl, sel;
      bit  qual, src, all_flip, rst_phase;
      @(posedge sysclk);
      cyc++;
      if (sysreset) begin
        mdiv = 0; mctrl = 0; mcount = 1;
        hist.delete(); lvl = 1'b0; chg = 1'b0;
        exp_q.delete();
      end else begin
        n = hist.size();
        hist.push_back(ext_in);
        sel  = (mctrl >> 2) & 3;
        qual = chg && ((sel == 2) || ((sel == 1) ? !lvl : lvl));
        src  = (mctrl & 2) != 0 ? qual : 1'b1;
        all_flip = 1'b1;
        for (int j = n - int'(FL) + 1; j <= n; j++)
          if (samp(j) == lvl) all_flip = 1'b0;
        chg = all_flip;
        if (all_flip) lvl = !lvl;
        ndiv   = load_divisor ? int'(data_in) : mdiv;
        nctrl  = load_ctrl ? int'(data_in[3:0]) : mctrl;
        neweff = (ndiv == 0) ? 1 : ndiv;
        rst_phase = load_divisor ||
                    (load_ctrl && ((((mctrl & 1) == 0) && data_in[0]) ||
                                   (((mctrl >> 1) & 1) != int'(data_in[1]))));
        if (load_divisor || load_ctrl) begin
          if (rst_phase) mcount = neweff;
        end else if ((mctrl & 1) != 0 && src) begin
          if (mcount == 0) begin
            exp_q.push_back(cyc);
            mcount = neweff;
          end else begin
            mcount--;
          end
        end
        mdiv = ndiv;
        mctrl = nctrl;
      end
    end
  end

  // Monitor: compare pulses and readback against the model
  initial begin
    bit prev_ev = 1'b0;
    forever begin
      @(posedge sysclk);
      #1;
      if (sysreset) begin
        prev_ev = 1'b0;
      end else begin
        chk("readback", int'(data_out), rd_sel ? (mctrl & 15) : mdiv);
        if (counter_event) begin
          pulses++;
          if (timer > 0) timer--;
          if (prev_ev) chk("pulse_width", 2, 1);
          if (exp_q.size() == 0) begin
            chk("spurious_pulse", cyc, -1);
          end else begin
            chk("pulse_cycle", cyc, exp_q.pop_front());
          end
        end else if (exp_q.size() != 0 && exp_q[0] <= cyc) begin
          chk("missed_pulse", -1, exp_q.pop_front());
        end
        prev_ev = counter_event;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic wr_div(input logic [15:0] v);
    data_in = v; load_divisor = 1'b1;
    @(negedge sysclk);
    load_divisor = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [3:0] v);
    data_in = {12'b0, v}; load_ctrl = 1'b1;
    @(negedge sysclk);
    load_ctrl = 1'b0;
  endtask

  task automatic ext_steps(input int unsigned n, input int unsigned hold);
    for (int unsigned i = 0; i < n; i++) begin
      ext_in = 1'b1; tick(hold);
      ext_in = 1'b0; tick(hold);
    end
  endtask

  initial begin
    int p0, lat;
    bit found;

    // Reset state
    tick(3);
    chk("reset_event", int'(counter_event), 0);
    rd_sel = 1'b0; #1 chk("reset_div", int'(data_out), 0);
    rd_sel = 1'b1; #1 chk("reset_ctrl", int'(data_out), 0);
    rd_sel = 1'b0;
    sysreset = 1'b0;
    tick(2);

    // Internal source, divisor 3: a pulse every 4 cycles
    wr_div(16'd3);
    #1 chk("rb_div3", int'(data_out), 3);
    p0 = pulses;
    wr_ctrl(4'h1);
    rd_sel = 1'b1; #1 chk("rb_ctrl1", int'(data_out), 1);
    rd_sel = 1'b0;
    tick(20);
    chk("int_div3_count", pulses - p0, 5);

    // Divisor 0 clamps to 1: a pulse every 2 cycles
    p0 = pulses;
    wr_div(16'd0);
    tick(20);
    chk("int_div0_count", pulses - p0, 10);

    // External rising edges, divisor 0
    p0 = pulses;
    wr_ctrl(4'h3);
    tick(10);
    ext_in = 1'b1; tick(10);
    ext_in = 1'b0; tick(10);
    ext_in = 1'b1; tick(3);
    ext_in = 1'b0; tick(12);
    chk("ext_no_pulse_yet", pulses - p0, 0);
    ext_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sysclk);
      if (counter_event) begin lat = i; break; end
    end
    chk("ext_rise_latency", lat, 7);
    tick(5);
    p0 = pulses;
    ext_in = 1'b0; tick(12);
    chk("ext_fall_ignored", pulses - p0, 0);

    // Both edges
    p0 = pulses;
    wr_ctrl(4'hB);
    ext_steps(2, 10);
    chk("ext_both_count", pulses - p0, 2);

    // Divisor 2 on rising edges, feeding a countdown timer loaded with 5
    wr_ctrl(4'h3);
    wr_div(16'd2);
    p0 = pulses;
    timer = 5;
    ext_steps(15, 8);
    chk("div2_pulses", pulses - p0, 5);
    chk("timer_zero", timer, 0);
    ext_steps(2, 8);
    chk("timer_hold", timer, 0);

    // Divisor write coinciding with the terminal count
    wr_ctrl(4'h1);
    wr_div(16'd3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mcount == 0) begin found = 1'b1; break; end
      @(negedge sysclk);
    end
    chk("terminal_found", int'(found), 1);
    p0 = pulses;
    wr_div(16'd3);
    chk("load_beats_terminal", pulses - p0, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sysclk);
      if (counter_event) begin lat = i; break; end
    end
    chk("after_load_latency", lat, 4);

    // Randomized operation
    for (int i = 0; i < 1500; i++) begin
      @(negedge sysclk);
      data_in      = 16'($urandom_range(0, 15));
      load_divisor = ($urandom_range(0, 99) < 6);
      load_ctrl    = ($urandom_range(0, 99) < 5);
      rd_sel       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 20) ext_in = ~ext_in;
      if ($urandom_range(0, 299) == 0) begin
        load_divisor = 1'b0; load_ctrl = 1'b0;
        sysreset = 1'b1;
        tick(2);
        sysreset = 1'b0;
      end
    end
    @(negedge sysclk);
    load_divisor = 1'b0; load_ctrl = 1'b0; rd_sel = 1'b0; ext_in = 1'b0;
    tick(3);

    // Reset while a pulse is high
    wr_div(16'd1);
    wr_ctrl(4'h0);
    wr_ctrl(4'h1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      if (counter_event) begin found = 1'b1; break; end
    end
    chk("mid_pulse_found", int'(found), 1);
    sysreset = 1'b1;
    #1 chk("rst_drops_pulse", int'(counter_event), 0);
    rd_sel = 1'b0; #1 chk("rst_div_clear", int'(data_out), 0);
    rd_sel = 1'b1; #1 chk("rst_ctrl_clear", int'(data_out), 0);
    rd_sel = 1'b0;
    tick(2);
    sysreset = 1'b0;
    tick(6);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
